// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider arbiter.
package div_ctrl_pkg;

    // Controller states. The encodings are fixed so that they can be probed directly.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Default operand/result width. Must match the attached divider.
    localparam int DIV_W_DEF       = 4;
    // Number of S_WAIT cycles after which a healthy divider shows div_valid.
    localparam int DIV_WAIT_NOM    = 6;
    // Default abort limit, counted in S_WAIT cycles.
    localparam int DIV_TIMEOUT_DEF = 15;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; only the last
// winner is stored, and it is updated when the consumer accepts a grant.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt,
    output logic any_req
);

    logic last_grant_reg;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        any_req = req0 | req1;
        gnt     = (req0 && req1) ? ~last_grant_reg : req1;
    end

    // Remember the winner. Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (take && any_req) begin
            last_grant_reg <= gnt;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two requesters. The winning operands
// are latched and held, the divider is started once, and the result is
// returned with a one-cycle ack. Divide-by-zero is answered without using
// the divider. A divider that never completes is aborted with err.
module div_arbiter
    import div_ctrl_pkg::*;
#(
    parameter int W       = DIV_W_DEF,
    parameter int TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] dv0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] dv1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] q_out,
    output logic [W-1:0] r_out,
    output logic         dz,
    output logic         err,
    output logic         busy,
    output logic         div_start,
    output logic [W-1:0] div_D,
    output logic [W-1:0] div_divider,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    input  logic         div_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           sel_reg, sel_next;
    logic [W-1:0]   div_D_next, div_divider_next, q_next, r_next;
    logic           dz_next, err_next, ack0_next, ack1_next, start_next;
    logic           gnt, any_req, take;
    logic [W-1:0]   op_d, op_dv;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .take    (take),
        .gnt     (gnt),
        .any_req (any_req)
    );

    assign op_d  = gnt ? d1  : d0;
    assign op_dv = gnt ? dv1 : dv0;
    assign busy  = (state_reg != S_IDLE);

    // State register; a reset in mid-operation drops the operation silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and next-value logic for every registered output.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        sel_next         = sel_reg;
        div_D_next       = div_D;
        div_divider_next = div_divider;
        q_next           = q_out;
        r_next           = r_out;
        dz_next          = dz;
        err_next         = err;
        ack0_next        = 1'b0;
        ack1_next        = 1'b0;
        start_next       = 1'b0;
        take             = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (any_req) begin
                    take             = 1'b1;
                    sel_next         = gnt;
                    div_D_next       = op_d;
                    div_divider_next = op_dv;
                    if (op_dv == '0) begin
                        // Answer directly; the divider is left untouched.
                        q_next     = '1;
                        r_next     = op_d;
                        dz_next    = 1'b1;
                        err_next   = 1'b0;
                        ack0_next  = ~gnt;
                        ack1_next  = gnt;
                        state_next = S_DONE;
                    end else begin
                        start_next = 1'b1;
                        state_next = S_START;
                    end
                end
            end
            S_START: begin
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt_reg + CW'(1);
                // div_valid may still be high from the previous operation in
                // the first wait cycle, so it is ignored while the count is 0.
                if ((cnt_reg != '0) && div_valid) begin
                    q_next     = div_q;
                    r_next     = div_r;
                    dz_next    = 1'b0;
                    err_next   = 1'b0;
                    ack0_next  = ~sel_reg;
                    ack1_next  = sel_reg;
                    state_next = S_DONE;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    q_next     = '0;
                    r_next     = '0;
                    dz_next    = 1'b0;
                    err_next   = 1'b1;
                    ack0_next  = ~sel_reg;
                    ack1_next  = sel_reg;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Operand, result, handshake and timeout-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            sel_reg     <= 1'b0;
            div_D       <= '0;
            div_divider <= '0;
            q_out       <= '0;
            r_out       <= '0;
            dz          <= 1'b0;
            err         <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            div_start   <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            sel_reg     <= sel_next;
            div_D       <= div_D_next;
            div_divider <= div_divider_next;
            q_out       <= q_next;
            r_out       <= r_next;
            dz          <= dz_next;
            err         <= err_next;
            ack0        <= ack0_next;
            ack1        <= ack1_next;
            div_start   <= start_next;
        end
    end

endmodule
